// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: TAP state encoding and instruction opcodes.
// The DMI request FSM imports this same package so both sides agree on
// the instruction values and state names.
package jtag_pkg;

    // The sixteen IEEE 1149.1 TAP controller states
    typedef enum logic [3:0] {
        TestLogicReset = 4'h0,
        RunTestIdle    = 4'h1,
        SelectDr       = 4'h2,
        CaptureDr      = 4'h3,
        ShiftDr        = 4'h4,
        Exit1Dr        = 4'h5,
        PauseDr        = 4'h6,
        Exit2Dr        = 4'h7,
        UpdateDr       = 4'h8,
        SelectIr       = 4'h9,
        CaptureIr      = 4'hA,
        ShiftIr        = 4'hB,
        Exit1Ir        = 4'hC,
        PauseIr        = 4'hD,
        Exit2Ir        = 4'hE,
        UpdateIr       = 4'hF
    } tap_state_t;

    // Instruction opcodes; any code not listed here selects BYPASS
    localparam logic [4:0] INSTR_BYPASS0 = 5'h00;
    localparam logic [4:0] INSTR_IDCODE  = 5'h01;
    localparam logic [4:0] INSTR_DTMCS   = 5'h10;
    localparam logic [4:0] INSTR_DMI     = 5'h11;
    localparam logic [4:0] INSTR_BYPASS1 = 5'h1F;

    // Fixed pattern loaded into the IR shift stage in Capture-IR
    localparam logic [4:0] IR_CAPTURE = 5'b00001;

endpackage

// File: rtl/jtag_ir.sv
// JTAG instruction register: capture/shift stage, parallel IR and the
// instruction decode that selects which data register sits behind TDO.
module jtag_ir
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic capture_i,
    input  logic shift_i,
    input  logic update_i,
    input  logic tlrEnter_i,
    input  logic tdi_i,
    output logic irShiftLsb_o,
    output logic idcodeSel_o,
    output logic dtmcsSel_o,
    output logic dmiSel_o
);

    logic [IR_WIDTH-1:0] irShift_q, irShift_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;

    // Shift stage loads the capture pattern, shifts LSB-first from TDI, and
    // the parallel IR takes the shifted value on Update-IR or falls back to
    // IDCODE whenever the TAP is heading into Test-Logic-Reset
    always_comb begin
        irShift_d = irShift_q;
        ir_d      = ir_q;
        if (capture_i) begin
            irShift_d = IR_WIDTH'(IR_CAPTURE);
        end else if (shift_i) begin
            irShift_d = {tdi_i, irShift_q[IR_WIDTH-1:1]};
        end
        if (tlrEnter_i) begin
            ir_d = IR_WIDTH'(INSTR_IDCODE);
        end else if (update_i) begin
            ir_d = irShift_q;
        end
    end

    // Register both stages; TRST_n puts IR back on IDCODE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irShift_q <= '0;
            ir_q      <= IR_WIDTH'(INSTR_IDCODE);
        end else begin
            irShift_q <= irShift_d;
            ir_q      <= ir_d;
        end
    end

    // Decode the held instruction; BYPASS is implied when nothing matches
    always_comb begin
        irShiftLsb_o = irShift_q[0];
        idcodeSel_o  = (ir_q == IR_WIDTH'(INSTR_IDCODE));
        dtmcsSel_o   = (ir_q == IR_WIDTH'(INSTR_DTMCS));
        dmiSel_o     = (ir_q == IR_WIDTH'(INSTR_DMI));
    end

endmodule

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller for the RISC-V Debug Transport Module.
// Owns the TAP state machine, the IDCODE and BYPASS data registers and the
// negedge TDO mux; the instruction register lives in jtag_ir. The external
// DMI and DTMCS shift registers are driven from the strobes below.
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 5,
    parameter logic [31:0] IDCODE_VALUE = 32'h1002_AC05
) (
    input  logic clk,
    input  logic reset,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    output logic tdo_en,
    input  logic dmi_tdo,
    input  logic dtmcs_tdo,
    output logic dmi_select,
    output logic dtmcs_select,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic test_logic_reset,
    output logic run_test_idle
);

    tap_state_t  state_q, state_d;
    logic        captureIr, shiftIr, updateIr, tlrEnter;
    logic        irShiftLsb, idcodeSel;
    logic [31:0] idcodeSr_q, idcodeSr_d;
    logic        bypass_q, bypass_d;
    logic        drBit;
    logic        tdo_q, tdo_d;
    logic        tdoEn_q, tdoEn_d;

    // TAP state register; TRST_n forces Test-Logic-Reset immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TestLogicReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard TMS-driven state transitions
    always_comb begin
        state_d = state_q;
        case (state_q)
            TestLogicReset: state_d = tms ? TestLogicReset : RunTestIdle;
            RunTestIdle:    state_d = tms ? SelectDr       : RunTestIdle;
            SelectDr:       state_d = tms ? SelectIr       : CaptureDr;
            CaptureDr:      state_d = tms ? Exit1Dr        : ShiftDr;
            ShiftDr:        state_d = tms ? Exit1Dr        : ShiftDr;
            Exit1Dr:        state_d = tms ? UpdateDr       : PauseDr;
            PauseDr:        state_d = tms ? Exit2Dr        : PauseDr;
            Exit2Dr:        state_d = tms ? UpdateDr       : ShiftDr;
            UpdateDr:       state_d = tms ? SelectDr       : RunTestIdle;
            SelectIr:       state_d = tms ? TestLogicReset : CaptureIr;
            CaptureIr:      state_d = tms ? Exit1Ir        : ShiftIr;
            ShiftIr:        state_d = tms ? Exit1Ir        : ShiftIr;
            Exit1Ir:        state_d = tms ? UpdateIr       : PauseIr;
            PauseIr:        state_d = tms ? Exit2Ir        : PauseIr;
            Exit2Ir:        state_d = tms ? UpdateIr       : ShiftIr;
            UpdateIr:       state_d = tms ? SelectDr       : RunTestIdle;
        endcase
    end

    assign tlrEnter = (state_d == TestLogicReset);

    // Moore strobes: straight decodes of the registered state
    always_comb begin
        capture_dr       = (state_q == CaptureDr);
        shift_dr         = (state_q == ShiftDr);
        update_dr        = (state_q == UpdateDr);
        test_logic_reset = (state_q == TestLogicReset);
        run_test_idle    = (state_q == RunTestIdle);
        captureIr        = (state_q == CaptureIr);
        shiftIr          = (state_q == ShiftIr);
        updateIr         = (state_q == UpdateIr);
    end

    jtag_ir #(
        .IR_WIDTH (IR_WIDTH)
    ) u_ir (
        .clk          (clk),
        .reset        (reset),
        .capture_i    (captureIr),
        .shift_i      (shiftIr),
        .update_i     (updateIr),
        .tlrEnter_i   (tlrEnter),
        .tdi_i        (tdi),
        .irShiftLsb_o (irShiftLsb),
        .idcodeSel_o  (idcodeSel),
        .dtmcsSel_o   (dtmcs_select),
        .dmiSel_o     (dmi_select)
    );

    // IDCODE only moves when selected; BYPASS captures/shifts regardless of
    // IR since it is only observed on TDO when nothing else is selected
    always_comb begin
        idcodeSr_d = idcodeSr_q;
        bypass_d   = bypass_q;
        if (capture_dr) begin
            bypass_d = 1'b0;
            if (idcodeSel) begin
                idcodeSr_d = IDCODE_VALUE;
            end
        end else if (shift_dr) begin
            bypass_d = tdi;
            if (idcodeSel) begin
                idcodeSr_d = {tdi, idcodeSr_q[31:1]};
            end
        end
    end

    // Data register storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idcodeSr_q <= '0;
            bypass_q   <= 1'b0;
        end else begin
            idcodeSr_q <= idcodeSr_d;
            bypass_q   <= bypass_d;
        end
    end

    // Select the DR bit presented on TDO according to the instruction
    always_comb begin
        if (idcodeSel) begin
            drBit = idcodeSr_q[0];
        end else if (dtmcs_select) begin
            drBit = dtmcs_tdo;
        end else if (dmi_select) begin
            drBit = dmi_tdo;
        end else begin
            drBit = bypass_q;
        end
    end

    // TDO is only driven in the two shift states; otherwise it holds
    always_comb begin
        tdo_d   = tdo_q;
        tdoEn_d = 1'b0;
        if (shiftIr) begin
            tdo_d   = irShiftLsb;
            tdoEn_d = 1'b1;
        end else if (shift_dr) begin
            tdo_d   = drBit;
            tdoEn_d = 1'b1;
        end
    end

    // TDO changes on the falling edge so the host samples it on the rising edge
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            tdo_q   <= 1'b0;
            tdoEn_q <= 1'b0;
        end else begin
            tdo_q   <= tdo_d;
            tdoEn_q <= tdoEn_d;
        end
    end

    assign tdo    = tdo_q;
    assign tdo_en = tdoEn_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: a behavioural TAP model is checked
// against the DUT every cycle, plus directed scans with literal results.
module tb_jtag_tap;

    logic clk = 1'b0;
    logic reset;
    logic tms, tdi, dmi_tdo, dtmcs_tdo;
    logic tdo, tdo_en, dmi_select, dtmcs_select;
    logic capture_dr, shift_dr, update_dr, test_logic_reset, run_test_idle;

    int testsRun    = 0;
    int testsFailed = 0;

    jtag_tap dut (
        .clk              (clk),
        .reset            (reset),
        .tms              (tms),
        .tdi              (tdi),
        .tdo              (tdo),
        .tdo_en           (tdo_en),
        .dmi_tdo          (dmi_tdo),
        .dtmcs_tdo        (dtmcs_tdo),
        .dmi_select       (dmi_select),
        .dtmcs_select     (dtmcs_select),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .test_logic_reset (test_logic_reset),
        .run_test_idle    (run_test_idle)
    );

    always #5 clk = ~clk;

    // Model states: 0 TLR, 1 RTI, DR chain 2..8, IR chain 9..15 in the same order
    localparam int M_TLR = 0, M_RTI = 1;
    localparam int M_SEL = 2, M_CAP = 3, M_SHIFT = 4, M_EX1 = 5, M_PAUSE = 6, M_EX2 = 7, M_UPD = 8;
    localparam int IR_OFS = 7;

    int          mState  = M_TLR;
    logic [4:0]  mIr     = 5'h01;
    logic [4:0]  mIrSh   = '0;
    logic [31:0] mIdcode = '0;
    logic        mBypass = 1'b0;
    logic        mTdo    = 1'b0;
    logic        mTdoEn  = 1'b0;

    logic capQ[$];
    int   updCount = 0;
    int   shCount  = 0;

    function automatic int nextOf(int s, logic t);
        int ofs, base, r;
        if (s == M_TLR) return t ? M_TLR : M_RTI;
        if (s == M_RTI) return t ? M_SEL : M_RTI;
        if (s == M_SEL) return t ? M_SEL + IR_OFS : M_CAP;
        if (s == M_SEL + IR_OFS) return t ? M_TLR : M_CAP + IR_OFS;
        ofs  = (s > M_UPD) ? IR_OFS : 0;
        base = s - ofs;
        if (base == M_UPD) return t ? M_SEL : M_RTI;
        case (base)
            M_CAP, M_SHIFT: r = t ? M_EX1 : M_SHIFT;
            M_EX1:          r = t ? M_UPD : M_PAUSE;
            M_PAUSE:        r = t ? M_EX2 : M_PAUSE;
            default:        r = t ? M_UPD : M_SHIFT;
        endcase
        return r + ofs;
    endfunction

    function automatic logic selectedDrBit();
        case (mIr)
            5'h01:   return mIdcode[0];
            5'h10:   return dtmcs_tdo;
            5'h11:   return dmi_tdo;
            default: return mBypass;
        endcase
    endfunction

    // Model: TAP step and register effects on the rising edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mState = M_TLR; mIr = 5'h01; mIrSh = '0; mIdcode = '0; mBypass = 1'b0;
        end else begin
            if (mState == M_CAP + IR_OFS)   mIrSh = 5'b00001;
            if (mState == M_SHIFT + IR_OFS) mIrSh = {tdi, mIrSh[4:1]};
            if (mState == M_UPD + IR_OFS)   mIr = mIrSh;
            if (mState == M_CAP) begin
                mBypass = 1'b0;
                if (mIr == 5'h01) mIdcode = 32'h1002_AC05;
            end
            if (mState == M_SHIFT) begin
                if (mIr == 5'h01) mIdcode = {tdi, mIdcode[31:1]};
                mBypass = tdi;
            end
            mState = nextOf(mState, tms);
            if (mState == M_TLR) mIr = 5'h01;
        end
    end

    // Model: TDO on the falling edge
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            mTdo = 1'b0; mTdoEn = 1'b0;
        end else if (mState == M_SHIFT + IR_OFS) begin
            mTdo = mIrSh[0]; mTdoEn = 1'b1;
        end else if (mState == M_SHIFT) begin
            mTdo = selectedDrBit(); mTdoEn = 1'b1;
        end else begin
            mTdoEn = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle compare against the model, plus TDO capture for directed scans
    always @(negedge clk) begin
        #1;
        checkOutput("tdo", tdo, mTdo);
        checkOutput("tdo_en", tdo_en, mTdoEn);
        checkOutput("dmi_select", dmi_select, mIr == 5'h11);
        checkOutput("dtmcs_select", dtmcs_select, mIr == 5'h10);
        checkOutput("capture_dr", capture_dr, mState == M_CAP);
        checkOutput("shift_dr", shift_dr, mState == M_SHIFT);
        checkOutput("update_dr", update_dr, mState == M_UPD);
        checkOutput("test_logic_reset", test_logic_reset, mState == M_TLR);
        checkOutput("run_test_idle", run_test_idle, mState == M_RTI);
        if (tdo_en === 1'b1) capQ.push_back(tdo);
        if (update_dr === 1'b1) updCount++;
        if (shift_dr === 1'b1) shCount++;
    end

    task automatic applyStimulus(input logic t, input logic d);
        @(negedge clk);
        #2;
        tms       = t;
        tdi       = d;
        dmi_tdo   = 1'($urandom);
        dtmcs_tdo = 1'($urandom);
    endtask

    task automatic scanIr(input logic [4:0] v, output logic [4:0] got);
        capQ.delete();
        applyStimulus(1, 0); applyStimulus(1, 0); applyStimulus(0, 0); applyStimulus(0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(i == 4, v[i]);
        applyStimulus(1, 0); applyStimulus(0, 0); applyStimulus(0, 0);
        checkOutput("ir_scan_len", 64'(capQ.size()), 64'd5);
        got = '0;
        for (int i = 0; i < 5 && i < capQ.size(); i++) got[i] = capQ[i];
    endtask

    task automatic scanDr(input int n, input logic [63:0] data, output logic [63:0] got);
        capQ.delete();
        applyStimulus(1, 0); applyStimulus(0, 0); applyStimulus(0, 0);
        for (int i = 0; i < n; i++) applyStimulus(i == n - 1, data[i]);
        applyStimulus(1, 0); applyStimulus(0, 0); applyStimulus(0, 0);
        checkOutput("dr_scan_len", 64'(capQ.size()), 64'(n));
        got = '0;
        for (int i = 0; i < n && i < capQ.size(); i++) got[i] = capQ[i];
    endtask

    task automatic gotoIdle();
        repeat (5) applyStimulus(1, 0);
        applyStimulus(0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0]  irGot;
        logic [63:0] drGot, drData;
        string       paths[16];
        logic [4:0]  irPick[4];

        paths = '{"111", "", "1", "10", "100", "101", "1010", "10101", "1011",
                  "11", "110", "1100", "1101", "11010", "110101", "11011"};
        irPick = '{5'h01, 5'h10, 5'h11, 5'h00};

        reset = 1'b0; tms = 1'b1; tdi = 1'b0; dmi_tdo = 1'b0; dtmcs_tdo = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("reset_tlr", test_logic_reset, 1'b1);
        checkOutput("reset_rti", run_test_idle, 1'b0);
        checkOutput("reset_tdo_en", tdo_en, 1'b0);
        checkOutput("reset_tdo", tdo, 1'b0);
        checkOutput("reset_dmi_sel", dmi_select, 1'b0);
        reset = 1'b1;
        applyStimulus(0, 0);

        // IDCODE read straight out of reset
        scanDr(32, 64'd0, drGot);
        checkOutput("idcode_scan", drGot[31:0], 32'h1002_AC05);

        // Load DMI and check the IR capture pattern and decode
        scanIr(5'h11, irGot);
        checkOutput("ir_capture_bits", irGot, 5'b00001);
        checkOutput("dmi_sel_after_ir", dmi_select, 1'b1);
        checkOutput("dtmcs_sel_after_ir", dtmcs_select, 1'b0);

        // DMI data scan: one update pulse, shift_dr for exactly N cycles
        updCount = 0; shCount = 0;
        drData = {$urandom, $urandom};
        scanDr(40, drData, drGot);
        checkOutput("dmi_update_pulses", 64'(updCount), 64'd1);
        checkOutput("dmi_shift_cycles", 64'(shCount), 64'd40);

        scanIr(5'h10, irGot);
        checkOutput("dtmcs_sel", dtmcs_select, 1'b1);
        checkOutput("dtmcs_dmi_sel", dmi_select, 1'b0);

        // Unassigned code behaves as BYPASS
        scanIr(5'h07, irGot);
        scanDr(9, 64'h0A5, drGot);
        checkOutput("bypass_a5", drGot[8:0], 9'h14A);
        scanIr(5'h1F, irGot);
        drData = {$urandom, $urandom};
        scanDr(16, drData, drGot);
        checkOutput("bypass_1f", drGot[15:0], {drData[14:0], 1'b0});
        scanIr(5'h00, irGot);
        drData = {$urandom, $urandom};
        scanDr(16, drData, drGot);
        checkOutput("bypass_00", drGot[15:0], {drData[14:0], 1'b0});

        // Asynchronous reset in the middle of a DMI shift
        scanIr(5'h11, irGot);
        updCount = 0;
        applyStimulus(1, 0); applyStimulus(0, 0); applyStimulus(0, 0);
        applyStimulus(0, 1); applyStimulus(0, 1);
        #1 reset = 1'b0;
        #1;
        checkOutput("midshift_tlr", test_logic_reset, 1'b1);
        checkOutput("midshift_tdo_en", tdo_en, 1'b0);
        checkOutput("midshift_shift_dr", shift_dr, 1'b0);
        checkOutput("midshift_dmi_sel", dmi_select, 1'b0);
        applyStimulus(0, 0);
        reset = 1'b1;
        applyStimulus(0, 0);
        checkOutput("post_reset_rti", run_test_idle, 1'b1);
        checkOutput("midshift_no_update", 64'(updCount), 64'd0);
        scanDr(32, 64'd0, drGot);
        checkOutput("post_reset_idcode", drGot[31:0], 32'h1002_AC05);

        // Five TMS=1 cycles reach Test-Logic-Reset from each of the 16 states
        for (int s = 0; s < 16; s++) begin
            scanIr(5'h11, irGot);
            for (int i = 0; i < paths[s].len(); i++) applyStimulus(paths[s][i] == "1", 0);
            repeat (5) applyStimulus(1, 0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("tms5_tlr_from_%0d", s), test_logic_reset, 1'b1);
            checkOutput($sformatf("tms5_dmi_sel_from_%0d", s), dmi_select, 1'b0);
            checkOutput($sformatf("tms5_dtmcs_sel_from_%0d", s), dtmcs_select, 1'b0);
            applyStimulus(0, 0);
        end

        // Randomised traffic, with periodic IR loads and occasional resets
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                gotoIdle();
                scanIr(($urandom_range(0, 1) == 0) ? irPick[$urandom_range(0, 3)] : 5'($urandom), irGot);
            end
            applyStimulus($urandom_range(0, 99) < 30, 1'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
